ttc_frame_packer: RTL and testbench



---
 rtl/ttc_frame_packer.sv | 149 ++++++++++++++
 tb/tb_ttc_frame_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_frame_packer.sv
// Buffers one TTC telemetry payload and emits ASM | length | payload | CRC-16 frames
// over a valid/ready byte stream.
module ttc_frame_packer #(
  parameter int          PAYLOAD_LEN  = 220,
  parameter int          IDLE_TIMEOUT = 64,
  parameter logic [31:0] ASM          = 32'h1ACFFC1D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [3:0] COLLECT = 4'd0;
  localparam logic [3:0] ASM0    = 4'd1;
  localparam logic [3:0] ASM1    = 4'd2;
  localparam logic [3:0] ASM2    = 4'd3;
  localparam logic [3:0] ASM3    = 4'd4;
  localparam logic [3:0] LEN     = 4'd5;
  localparam logic [3:0] PAYLOAD = 4'd6;
  localparam logic [3:0] CRC_HI  = 4'd7;
  localparam logic [3:0] CRC_LO  = 4'd8;

  localparam int          TW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]  LEN_C    = 8'(PAYLOAD_LEN);
  localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

  logic [3:0]    state;
  logic [7:0]    count;
  logic [TW-1:0] tmo;
  logic [7:0]    rd_ptr;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data;
  logic [15:0]   crc;
  logic [15:0]   crc_nx;
  logic          xfer;
  logic          start;
  logic [7:0]    mem [PAYLOAD_LEN];

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  assign xfer   = out_valid & out_ready;
  assign crc_nx = crc_byte(crc, out_data);
  assign busy   = (state != COLLECT);

  always_comb begin
    start = 1'b0;
    if (state == COLLECT) begin
      if (in_en) start = (count == LAST_IDX);
      else       start = (count != 8'd0) && (tmo == TMO_LAST);
    end
  end

  // rd_data always holds mem[rd_ptr], so the next payload byte is ready at each handshake
  always_comb begin
    rd_addr = rd_ptr;
    if (xfer && (state == LEN || state == PAYLOAD)) rd_addr = rd_ptr + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (state == COLLECT && in_en) mem[count] <= in_data;
    rd_data <= (rd_addr < LEN_C) ? mem[rd_addr] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      count     <= 8'd0;
      tmo       <= '0;
      rd_ptr    <= 8'd0;
      crc       <= 16'hFFFF;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      if (in_en && state != COLLECT && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      rd_ptr <= rd_addr;
      if (state == COLLECT) begin
        if (in_en) begin
          count <= count + 8'd1;
          tmo   <= '0;
        end else if (count != 8'd0) begin
          tmo <= tmo + 1'b1;
        end
        if (start) begin
          state     <= ASM0;
          out_valid <= 1'b1;
          out_data  <= ASM[31:24];
          out_sof   <= 1'b1;
          crc       <= 16'hFFFF;
          rd_ptr    <= 8'd0;
          tmo       <= '0;
        end
      end else if (xfer) begin
        out_sof <= 1'b0;
        case (state)
          ASM0: begin state <= ASM1; out_data <= ASM[23:16]; end
          ASM1: begin state <= ASM2; out_data <= ASM[15:8]; end
          ASM2: begin state <= ASM3; out_data <= ASM[7:0]; end
          ASM3: begin state <= LEN;  out_data <= count; end
          LEN:  begin state <= PAYLOAD; out_data <= rd_data; end
          PAYLOAD: begin
            crc <= crc_nx;
            if (rd_ptr == count) begin
              state    <= CRC_HI;
              out_data <= crc_nx[15:8];
            end else begin
              out_data <= rd_data;
            end
          end
          CRC_HI: begin
            state    <= CRC_LO;
            out_data <= crc[7:0];
            out_eof  <= 1'b1;
          end
          default: begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_eof   <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            count     <= 8'd0;
            tmo       <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttc_frame_packer.sv
// Scoreboard bench for ttc_frame_packer: a byte-level frame model predicts every output
// byte, while a negedge monitor compares handshakes, hold stability and status.
module tb_ttc_frame_packer;
  localparam int PLEN = 220;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_en = 1'b0;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, busy;
  logic [15:0] frame_cnt, drop_cnt;

  ttc_frame_packer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic sof; logic eof;} exp_t;
  typedef logic [7:0] bq_t [$];

  exp_t  exp_q [$];
  bq_t   pl;
  int    vectors = 0;
  int    miscompares = 0;
  int    idle = 0, remaining = 0, m_sent = 0;
  int    m_frames = 0, m_drops = 0;
  bit    m_busy = 0;
  bit    rand_ready = 0;
  bit    ready_fixed = 1;
  longint cyc = 0;
  longint sof_cyc = 0, eof_cyc = 0;
  logic [7:0] last_hi = 0, last_lo = 0, last_len = 0;
  int    frame_idx = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_crc(input bq_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic start_frame();
    logic [31:0] asm_w = 32'h1ACFFC1D;
    logic [15:0] c = ref_crc(pl);
    int n = pl.size();
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: asm_w[31-8*i -: 8], sof: (i == 0), eof: 1'b0});
    exp_q.push_back('{d: 8'(n), sof: 1'b0, eof: 1'b0});
    foreach (pl[i]) exp_q.push_back('{d: pl[i], sof: 1'b0, eof: 1'b0});
    exp_q.push_back('{d: c[15:8], sof: 1'b0, eof: 1'b0});
    exp_q.push_back('{d: c[7:0], sof: 1'b0, eof: 1'b1});
    remaining = n + 7;
    m_busy = 1;
    m_sent = 0;
    pl.delete();
    idle = 0;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) out_ready <= rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;

  // Reference model: frame-level bookkeeping of payload, idle time and accepted bytes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pl.delete(); exp_q.delete();
      idle = 0; m_busy = 0; remaining = 0; m_sent = 0; m_frames = 0; m_drops = 0;
    end else if (!m_busy) begin
      if (in_en) begin
        pl.push_back(in_data);
        idle = 0;
        if (pl.size() == PLEN) start_frame();
      end else if (pl.size() > 0) begin
        idle++;
        if (idle == TMO) start_frame();
      end
    end else begin
      if (in_en && m_drops != 65535) m_drops++;
      if (out_ready) begin
        m_sent++;
        remaining--;
        if (remaining == 0) begin m_busy = 0; m_frames++; end
      end
    end
  end

  bit         hold_pending = 0;
  logic [9:0] held;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
      frame_idx = 0;
    end else begin
      chk("valid", out_valid, m_busy);
      chk("busy", busy, m_busy);
      if (out_valid && hold_pending) chk("hold_stable", {out_data, out_sof, out_eof}, held);
      if (out_valid && out_ready) begin
        hold_pending = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {out_data, out_sof, out_eof}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", {out_data, out_sof, out_eof}, {e.d, e.sof, e.eof});
        end
        if (out_sof) begin sof_cyc = cyc; frame_idx = 0; end
        if (frame_idx == 4) last_len = out_data;
        frame_idx++;
        if (out_eof) begin eof_cyc = cyc; last_lo = out_data; end
        else last_hi = out_data;
      end else if (out_valid) begin
        hold_pending = 1;
        held = {out_data, out_sof, out_eof};
      end else begin
        hold_pending = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(int n, int mode, logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_en = 1'b1;
      in_data = (mode == 0) ? 8'(base + i) : 8'($urandom);
      tick();
    end
    in_en = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int k = 0;
    in_en = 1'b0;
    while ((m_busy || pl.size() != 0 || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: frame not completed within %0d cycles", name, budget);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    tick(); tick();
    chk("rst_out_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sof_eof", {out_sof, out_eof}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", {frame_cnt, drop_cnt}, 0);
    rst = 1'b0;
    tick();

    // 1: full generator burst
    burst(PLEN, 0, 8'h00);
    wait_done("t1_full", 1000);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_drop_cnt", drop_cnt, 0);
    chk("t1_contiguous", 32'(eof_cyc - sof_cyc), 226);

    // 2: partial payload flushed by idle timeout
    burst(9, 0, 8'h31);
    wait_done("t2_timeout", 1000);
    chk("t2_crc", {last_hi, last_lo}, 16'h29B1);
    chk("t2_len", last_len, 9);
    chk("t2_contiguous", 32'(eof_cyc - sof_cyc), 15);
    chk("t2_frame_cnt", frame_cnt, m_frames);

    // 3: random back-pressure
    rand_ready = 1;
    burst(PLEN, 0, 8'h00);
    wait_done("t3_backpressure", 3000);
    rand_ready = 0;
    chk("t3_frame_cnt", frame_cnt, 3);

    // 4: bytes arriving mid-frame are dropped
    burst(PLEN, 0, 8'h00);
    repeat (10) tick();
    burst(5, 1, 8'h00);
    wait_done("t4_drop", 1000);
    chk("t4_drop_cnt", drop_cnt, 5);
    burst(PLEN, 1, 8'h00);
    wait_done("t4_next", 1000);
    chk("t4_drop_after", drop_cnt, m_drops);

    // 5: a byte arriving on the would-be timeout cycle cancels the flush
    burst(3, 1, 8'h00);
    repeat (TMO - 1) tick();
    in_en = 1'b1; in_data = 8'($urandom); tick(); in_en = 1'b0;
    chk("t5_no_flush", busy, 0);
    repeat (TMO - 1) tick();
    chk("t5_still_collect", busy, 0);
    tick();
    chk("t5_flush", busy, 1);
    wait_done("t5_race", 1000);
    chk("t5_len", last_len, 4);

    // random frames with short gaps and random back-pressure
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        in_en = 1'b1; in_data = 8'($urandom); tick();
        in_en = 1'b0;
        repeat ($urandom_range(0, 8)) tick();
      end
      wait_done("rand_frame", 3000);
    end
    rand_ready = 0;
    chk("rand_frame_cnt", frame_cnt, m_frames);

    // drop counter saturation while downstream is stalled
    ready_fixed = 0;
    tick();
    burst(PLEN, 1, 8'h00);
    for (int i = 0; i < 65540; i++) begin
      in_en = 1'b1; in_data = 8'($urandom); tick();
    end
    in_en = 1'b0;
    chk("sat_drop_cnt", drop_cnt, 16'hFFFF);
    chk("sat_model", drop_cnt, m_drops);
    ready_fixed = 1;
    wait_done("sat_release", 1000);

    // 6: reset during payload byte 100
    burst(PLEN, 1, 8'h00);
    k = 0;
    while (m_sent != 105 && k < 2000) begin tick(); k++; end
    if (k >= 2000) begin
      vectors++; miscompares++;
      $display("FAIL t6_reach: payload byte 100 never presented");
    end
    chk("t6_mid_frame", busy, 1);
    rst = 1'b1;
    tick();
    chk("t6_out_data", out_data, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_sof_eof", {out_sof, out_eof}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_counts", {frame_cnt, drop_cnt}, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("t6_no_resume", busy, 0);
    burst(PLEN, 1, 8'h00);
    wait_done("t6_clean", 1000);
    chk("t6_frame_cnt", frame_cnt, 1);
    chk("t6_drop_cnt", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
